// File: rtl/if_pkg.sv
// Shared types and default constants for the instruction-fetch stage.
package if_pkg;

  // Fetch-stage lifecycle: wait for program load, issue the first
  // address, fetch continuously, then park until reset.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BOOT = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } fetch_state_e;

  // addi x0,x0,0 -- shown on instr whenever the fetch is not valid.
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  // First PC fetched after the program image is loaded.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Word-address width of the instruction memory.
  localparam int unsigned DEFAULT_IMEM_ADDR_W = 14;

endpackage

// File: rtl/fetch_pc_sel.sv
// Next fetch address selection: redirect beats stall beats sequential
// increment. Redirect targets are forced to word alignment.
module fetch_pc_sel
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  fetch_state_e state_i,
  input  logic [31:0]  pc_i,
  input  logic         stall_i,
  input  logic         redirect_i,
  input  logic [31:0]  redirect_pc_i,
  output logic [31:0]  next_addr_o
);

  // Choose the address handed to imem this cycle; outside RUN the
  // address is pinned (reset PC before running, held PC once halted).
  always_comb begin
    next_addr_o = pc_i;
    unique case (state_i)
      IDLE, BOOT: next_addr_o = RESET_PC;
      RUN: begin
        if (redirect_i) begin
          next_addr_o = redirect_pc_i & 32'hFFFF_FFFC;
        end else if (stall_i) begin
          next_addr_o = pc_i;
        end else begin
          next_addr_o = pc_i + 32'd4;
        end
      end
      HALT:    next_addr_o = pc_i;
      default: next_addr_o = pc_i;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC sequencing, synchronous imem read port
// driving, and the instr/pc/pc_plus4 bundle for the IF/ID register.
module fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_ADDR_W = DEFAULT_IMEM_ADDR_W,
  parameter logic [31:0] NOP_INSTR   = DEFAULT_NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   prog_loaded,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  input  logic                   halt,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            instr,
  output logic [31:0]            pc,
  output logic [31:0]            pc_plus4,
  output logic                   valid,
  output logic                   halted,
  output logic [31:0]            fetch_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  fetch_count_q, fetch_count_d;
  logic [31:0]  next_addr;

  fetch_pc_sel #(
    .RESET_PC(RESET_PC)
  ) u_pc_sel (
    .state_i      (state_q),
    .pc_i         (pc_q),
    .stall_i      (stall),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .next_addr_o  (next_addr)
  );

  // Word address to imem; upper bits drop so fetches wrap inside imem.
  assign imem_addr = IMEM_ADDR_W'(next_addr >> 2);

  // Next-state logic: halt is terminal, only reset leaves HALT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (prog_loaded) state_d = BOOT;
      BOOT:    state_d = RUN;
      RUN:     if (halt) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // pc_q tracks the address whose data arrives on imem_rdata, so it
  // follows next_addr on every edge where an address is being issued.
  always_comb begin
    pc_d = pc_q;
    if (state_q == BOOT || state_q == RUN) begin
      pc_d = next_addr;
    end
  end

  // Count delivered instructions, saturating instead of wrapping.
  always_comb begin
    fetch_count_d = fetch_count_q;
    if (valid && !stall && fetch_count_q != 32'hFFFF_FFFF) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  // State, PC and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign valid       = (state_q == RUN);
  assign halted      = (state_q == HALT);
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instr       = valid ? imem_rdata : NOP_INSTR;
  assign fetch_count = fetch_count_q;

endmodule
